// File: rtl/ram_host_port.sv
// Host access port that borrows RAM port A from the pairing core when the core is idle.
// Optional macro CONST_OVERLAY_EN: rd_data takes const_data instead of RAM data when const_eff is set.
module ram_host_port #(
  parameter int DW    = 198,
  parameter int AW    = 6,
  parameter int DRAIN = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_req,
  output logic          host_gnt,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic          host_w,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_data,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic          fsm_busy,
  input  logic [AW-1:0] fsm_addr,
  output logic [AW-1:0] ram_addr,
  output logic          ram_w,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  input  logic          const_eff,
  input  logic [DW-1:0] const_data,
  output logic          err
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOST, ST_DRAIN} state_t;

  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN - 1);

  state_t        state_reg, state_next;
  logic [2:0]    drain_cnt_reg, drain_cnt_next;
  logic          accept;
  logic          rd_issue;
  logic          rd_pend_reg;
  logic          fsm_busy_reg;
  logic          busy_rise;
  logic [DW-1:0] rd_word;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      drain_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
    end
  end

  // The core keeps priority: a grant is only taken once fsm_busy is low in WAIT.
  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = '0;
    case (state_reg)
      ST_IDLE: begin
        if (host_req) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (!host_req)      state_next = ST_IDLE;
        else if (!fsm_busy) state_next = ST_HOST;
      end
      ST_HOST: begin
        if (!host_req) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_cnt_reg == DRAIN_LAST) state_next = ST_IDLE;
        else drain_cnt_next = drain_cnt_reg + 3'd1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Write data is steered unconditionally; ram_w alone qualifies it.
  always_comb begin
    host_gnt   = 1'b0;
    host_ready = 1'b0;
    ram_addr   = fsm_addr;
    ram_w      = 1'b0;
    ram_wdata  = host_data;
    case (state_reg)
      ST_HOST: begin
        host_gnt   = 1'b1;
        host_ready = 1'b1;
        ram_addr   = host_addr;
        ram_w      = host_valid & host_w;
      end
      default: ;
    endcase
  end

  assign accept    = host_valid & host_ready;
  assign rd_issue  = accept & ~host_w;
  assign busy_rise = fsm_busy & ~fsm_busy_reg;

`ifdef CONST_OVERLAY_EN
  assign rd_word = const_eff ? const_data : ram_rdata;
`else
  logic unused_const;
  assign rd_word      = ram_rdata;
  assign unused_const = ^{const_eff, const_data};
`endif

  // Two-stage read return: RAM latency, then the rd_data register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_pend_reg <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
    end else begin
      rd_pend_reg <= rd_issue;
      rd_valid    <= rd_pend_reg;
      if (rd_pend_reg) rd_data <= rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_busy_reg <= 1'b0;
      err          <= 1'b0;
    end else begin
      fsm_busy_reg <= fsm_busy;
      if ((host_valid && !host_gnt) || (state_reg == ST_HOST && busy_rise)) err <= 1'b1;
    end
  end

endmodule

// File: doc/ram_host_port.md
RAM_HOST_PORT -- requirements
Module: ram_host_port

Interface
REQ-001 Parameter DW, default 198, RAM word width in bits.
REQ-002 Parameter AW, default 6, RAM address width in bits.
REQ-003 Parameter DRAIN, default 2, read-pipeline depth to drain before ownership release; legal values 1..4.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-low; sampled on rising clk edge.
REQ-006 host_req  in  1  host requests RAM port A ownership; level-sensitive.
REQ-007 host_gnt  out  1  host owns port A.
REQ-008 host_valid  in  1  host access request this cycle.
REQ-009 host_ready  out  1  access accepted when host_valid & host_ready.
REQ-010 host_w  in  1  1 = write, 0 = read.
REQ-011 host_addr  in  AW  host access address.
REQ-012 host_data  in  DW  host write data.
REQ-013 rd_valid  out  1  rd_data valid this cycle.
REQ-014 rd_data  out  DW  host read result.
REQ-015 fsm_busy  in  1  pairing core running.
REQ-016 fsm_addr  in  AW  core-side port A address.
REQ-017 ram_addr  out  AW  port A address to RAM.
REQ-018 ram_w  out  1  port A write enable.
REQ-019 ram_wdata  out  DW  port A write data.
REQ-020 ram_rdata  in  DW  port A read data; synchronous RAM, valid 1 cycle after address.
REQ-021 const_eff  in  1  constant overlay applies to the current read, aligned with ram_rdata.
REQ-022 const_data  in  DW  constant overlay word, aligned with ram_rdata.
REQ-023 err  out  1  sticky protocol error.

Function
REQ-024 FSM states are IDLE, WAIT, HOST and DRAIN.
REQ-025 IDLE: ram_addr = fsm_addr, ram_w = 0; host_req=1 -> WAIT.
REQ-026 WAIT: if host_req=0 -> IDLE; else if fsm_busy=0 -> HOST next cycle; else stay.
REQ-027 HOST: host_gnt=1, host_ready=1, ram_addr = host_addr, ram_w = host_valid & host_w, ram_wdata = host_data; host_req=0 -> DRAIN.
REQ-028 DRAIN: host_gnt=0, host_ready=0, ram_addr = fsm_addr, ram_w = 0; stay DRAIN cycles, then -> IDLE.
REQ-029 host_gnt and host_ready are 0 in all states other than HOST.
REQ-030 A read accepted in cycle N gives rd_valid=1 in cycle N+2 with the word read at host_addr of cycle N; rd_data is registered.
REQ-031 Back-to-back reads give one rd_valid per cycle in issue order; no stall.
REQ-032 A write accepted in cycle N followed by a read of the same address in N+1 returns the new data.
REQ-033 Reads accepted in the last HOST cycle still complete during DRAIN.
REQ-034 rd_valid is 0 for writes and when no access is accepted; rd_data holds its last value.
REQ-035 err sets when host_valid=1 and host_gnt=0.
REQ-036 err sets when fsm_busy rises while in HOST.
REQ-037 err clears only on reset.
REQ-038 host_req and fsm_busy both high in WAIT: the core keeps priority and no grant is issued.

Reset
REQ-039 When reset=0 at a clock edge, the block enters IDLE and flushes the read pipeline; pending reads are discarded with no rd_valid.
REQ-040 Reset values: host_gnt=0, host_ready=0, rd_valid=0, rd_data=0, err=0, ram_w=0.
REQ-041 Reset mid-HOST or mid-DRAIN returns the block to IDLE on the next edge.

Configuration
REQ-042 Macro CONST_OVERLAY_EN selects the read-data source.
REQ-043 With CONST_OVERLAY_EN defined, rd_data = const_data when const_eff=1, else ram_rdata.
REQ-044 Without CONST_OVERLAY_EN, rd_data = ram_rdata, and const_eff and const_data are ignored.

Verification
REQ-045 Scenario: host_req=1 while fsm_busy=0 -> host_gnt=1 two cycles later; ram_addr follows host_addr.
REQ-046 Scenario: write 0x1234 to addr 5, read addr 5 next cycle -> rd_valid two cycles after the read with rd_data=0x1234.
REQ-047 Scenario: host_req=1 while fsm_busy=1 for 10 cycles -> host_gnt stays 0 until fsm_busy falls.
REQ-048 Scenario: reads at addr 1,2,3 in consecutive cycles, host_req dropped with the last read -> three rd_valid pulses in order, host_gnt=0 during drain, IDLE after DRAIN cycles.
REQ-049 Scenario: host_valid=1 with no grant -> err=1 next cycle and held until reset=0.
REQ-050 Scenario: CONST_OVERLAY_EN defined, const_eff=1, const_data=0x1 on a read -> rd_data=0x1; without the macro, rd_data = RAM content.
